// File: rtl/serial_pkg.sv
// serial_pkg: shared width and capture-FSM state encoding for the serial receive path.
package serial_pkg;
   localparam int SER_DATA_W = 16;
   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_ACK  = 2'd1,
      RX_DROP = 2'd2
   } rx_state_t;
endpackage

// File: rtl/serial_fifo_mem.sv
// serial_fifo_mem: register-array FIFO storage with a synchronous write port
// and a synchronous read into a resettable output register.
module serial_fifo_mem
   import serial_pkg::*;
#(
   parameter int DATA_W = SER_DATA_W,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;

   // The read register holds its value when no pop occurs.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/serial_rx_buffer.sv
// serial_rx_buffer: acknowledges words from the SerialController with a one-cycle
// Read pulse and queues them in a FIFO that the consumer drains independently.
module serial_rx_buffer
   import serial_pkg::*;
#(
   parameter int DATA_W = SER_DATA_W,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              SerValid,
   input  logic [DATA_W-1:0] SerData,
   output logic              SerRead,
   input  logic              PopReq,
   output logic [DATA_W-1:0] PopData,
   output logic              PopValid,
   output logic              Empty,
   output logic              Full,
   output logic [ADDR_W:0]   Count,
   output logic              Stall
);
   rx_state_t         state, next;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_en, rd_en;

   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) state <= RX_IDLE;
      else state <= next;

   // DROP waits for Valid to fall so a slow controller cannot be captured twice.
   always_comb begin
      next = (state == RX_IDLE) ? (wr_en ? RX_ACK : RX_IDLE) :
             (state == RX_ACK)  ? RX_DROP :
             (SerValid ? RX_DROP : RX_IDLE);
   end

   always_comb begin
      SerRead = (state == RX_ACK);
      wr_en   = (state == RX_IDLE) && SerValid && !Full;
      rd_en   = PopReq && !Empty;
      Stall   = SerValid && Full;
   end

   assign Full  = (Count == (ADDR_W+1)'(DEPTH));
   assign Empty = (Count == '0);

   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         Count    <= '0;
         PopValid <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + ADDR_W'(wr_en);
         rd_ptr   <= rd_ptr + ADDR_W'(rd_en);
         Count    <= Count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
         PopValid <= rd_en;
      end

   serial_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
      .clk     (Clock),
      .rst_n   (Reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (SerData),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (PopData)
   );
endmodule

// File: tb/tb_serial_rx_buffer.sv
// tb_serial_rx_buffer: queue-based reference of the receive buffer compared every
// cycle, plus directed scenarios with literal expectations.
module tb_serial_rx_buffer;
   localparam int DEPTH = 8;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b1;
   logic        SerValid = 1'b0;
   logic [15:0] SerData = '0;
   logic        SerRead;
   logic        PopReq = 1'b0;
   logic [15:0] PopData;
   logic        PopValid;
   logic        Empty;
   logic        Full;
   logic [3:0]  Count;
   logic        Stall;

   int tests = 0;
   int fails = 0;
   int max_count = 0;

   serial_rx_buffer dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .SerValid (SerValid),
      .SerData  (SerData),
      .SerRead  (SerRead),
      .PopReq   (PopReq),
      .PopData  (PopData),
      .PopValid (PopValid),
      .Empty    (Empty),
      .Full     (Full),
      .Count    (Count),
      .Stall    (Stall)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a word queue plus the handshake rule "acknowledge one edge after
   // taking a word, and take no new word until Valid has been seen low".
   int q[$];
   bit ack_due = 0;
   bit ready = 1;
   bit exp_read = 0;
   bit exp_pvalid = 0;
   int exp_pdata = 0;

   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         q.delete();
         ack_due = 0;
         ready = 1;
         exp_read = 0;
         exp_pvalid = 0;
         exp_pdata = 0;
      end else begin
         automatic bit take = ready && !ack_due && SerValid && q.size() < DEPTH;
         automatic bit give = PopReq && q.size() > 0;
         if (ack_due) ack_due = 0;
         else if (!ready) ready = !SerValid;
         if (take) begin
            ready = 0;
            ack_due = 1;
         end
         exp_pvalid = give;
         if (give) exp_pdata = q.pop_front();
         if (take) q.push_back(int'(SerData));
         exp_read = ack_due;
      end
   end

   always @(negedge Clock) begin
      chk("SerRead", int'(SerRead), int'(exp_read));
      chk("PopValid", int'(PopValid), int'(exp_pvalid));
      chk("PopData", int'(PopData), exp_pdata);
      chk("Count", int'(Count), q.size());
      chk("Empty", int'(Empty), int'(q.size() == 0));
      chk("Full", int'(Full), int'(q.size() == DEPTH));
      chk("Stall", int'(Stall), int'(SerValid && q.size() == DEPTH));
      if (int'(Count) > max_count) max_count = int'(Count);
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic push(input int d);
      SerValid = 1'b1;
      SerData = 16'(d);
      tick();
      tick();
      SerValid = 1'b0;
      tick();
   endtask

   task automatic pop1();
      PopReq = 1'b1;
      tick();
      PopReq = 1'b0;
   endtask

   initial begin
      #1 Reset_n = 1'b0;
      #21 Reset_n = 1'b1;
      tick();
      chk("reset_count", int'(Count), 0);
      chk("reset_empty", int'(Empty), 1);
      chk("reset_popdata", int'(PopData), 0);

      // single word
      SerValid = 1'b1;
      SerData = 16'd685;
      tick();
      chk("single_count", int'(Count), 1);
      chk("single_read", int'(SerRead), 1);
      tick();
      chk("single_read_off", int'(SerRead), 0);
      tick();
      SerValid = 1'b0;
      tick();
      pop1();
      chk("single_pvalid", int'(PopValid), 1);
      chk("single_pdata", int'(PopData), 685);
      chk("single_empty", int'(Empty), 1);

      // Valid held long after the acknowledge
      SerValid = 1'b1;
      SerData = 16'h1111;
      repeat (7) tick();
      chk("late_count", int'(Count), 1);
      chk("late_read", int'(SerRead), 0);
      SerValid = 1'b0;
      tick();
      pop1();
      chk("late_pdata", int'(PopData), 16'h1111);

      // fill and stall
      for (int i = 1; i <= 8; i++) push(i);
      chk("fill_full", int'(Full), 1);
      chk("fill_count", int'(Count), 8);
      SerValid = 1'b1;
      SerData = 16'd345;
      tick();
      tick();
      chk("fill_stall", int'(Stall), 1);
      chk("fill_noread", int'(SerRead), 0);
      pop1();
      chk("fill_pop1", int'(PopData), 1);
      chk("fill_count7", int'(Count), 7);
      tick();
      chk("fill_refill", int'(Count), 8);
      chk("fill_read", int'(SerRead), 1);
      SerValid = 1'b0;
      tick();
      tick();
      PopReq = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         tick();
         chk("drain", int'(PopData), i);
      end
      tick();
      chk("drain_last", int'(PopData), 345);
      PopReq = 1'b0;
      tick();

      // wrap-around
      max_count = 0;
      for (int i = 0; i < 20; i++) begin
         push(100 + i);
         pop1();
         chk("wrap_order", int'(PopData), 100 + i);
      end
      chk("wrap_maxcount", int'(max_count <= 2), 1);

      // simultaneous capture and pop
      push(7);
      push(8);
      push(9);
      chk("sim_count3", int'(Count), 3);
      SerValid = 1'b1;
      SerData = 16'd10;
      PopReq = 1'b1;
      tick();
      PopReq = 1'b0;
      chk("sim_count", int'(Count), 3);
      chk("sim_pdata", int'(PopData), 7);
      tick();
      SerValid = 1'b0;
      tick();
      PopReq = 1'b1;
      repeat (3) tick();
      chk("sim_drain", int'(PopData), 10);
      tick();
      PopReq = 1'b0;
      chk("empty_pvalid", int'(PopValid), 0);
      chk("empty_pdata", int'(PopData), 10);

      // async reset during the acknowledge
      push(21);
      push(22);
      push(23);
      SerValid = 1'b1;
      SerData = 16'd44;
      tick();
      chk("rst_pre_count", int'(Count), 4);
      chk("rst_pre_read", int'(SerRead), 1);
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_read", int'(SerRead), 0);
      chk("rst_count", int'(Count), 0);
      chk("rst_empty", int'(Empty), 1);
      SerValid = 1'b0;
      @(negedge Clock);
      #1 Reset_n = 1'b1;
      tick();
      chk("post_count", int'(Count), 0);
      SerValid = 1'b1;
      SerData = 16'd55;
      tick();
      chk("post_capture", int'(Count), 1);
      chk("post_read", int'(SerRead), 1);
      SerValid = 1'b0;
      tick();
      pop1();
      chk("post_pdata", int'(PopData), 55);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
